cordic_magph_arb: RTL and testbench

//  Shares one serial cordicMagPh core between NREQ requesters using round-robin arbitration.

---
 rtl/cordic_magph_arb_pkg.sv | 43 ++++
 rtl/cordic_magph_arb_if.sv | 48 ++++
 rtl/cordic_magph_arb_rr_arbiter.sv | 39 +++
 rtl/cordic_magph_arb.sv | 185 ++++++++++++++++++
 tb/tb_cordic_magph_arb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_magph_arb_pkg.sv
// Shared types and helpers for the round-robin CORDIC magnitude/phase arbiter.
// Holds the FSM state enum, the round-robin pick function and the tag-width helper.
package cordic_magph_arb_pkg;

    localparam int unsigned MAX_REQ    = 16;
    localparam int unsigned MAX_ID_WDT = 4;

    typedef enum logic [2:0] {
        BOOT,
        ARB,
        START,
        BUSY,
        DONE
    } state_t;

    typedef struct packed {
        logic                  vld;
        logic [MAX_ID_WDT-1:0] idx;
    } pick_t;

    // Requester tag width; a 1-bit tag is the floor even for degenerate counts.
    function automatic int unsigned id_wdt(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // First set request at or above ptr, wrapping modulo nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]    req,
                                      input logic [MAX_ID_WDT-1:0] ptr,
                                      input int unsigned           nreq);
        pick_t                 p;
        logic [MAX_ID_WDT-1:0] idx;
        p = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = MAX_ID_WDT'((32'(ptr) + k) % nreq);
            if (k < nreq && !p.vld && req[idx]) begin
                p.vld = 1'b1;
                p.idx = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/cordic_magph_arb_if.sv
// Bus interfaces of the arbiter: requester/result side and serial-core side.
// The arbiter uses cordic_req_if.slave and cordic_core_if.master.
interface cordic_req_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned XY_WDT = 16
);
    import cordic_magph_arb_pkg::*;
    localparam int unsigned ID_WDT = id_wdt(NREQ);

    logic [NREQ-1:0]        req_vld;
    logic [NREQ*XY_WDT-1:0] req_x;
    logic [NREQ*XY_WDT-1:0] req_y;
    logic [NREQ-1:0]        req_ack;
    logic                   res_vld;
    logic [ID_WDT-1:0]      res_id;
    logic [XY_WDT-1:0]      res_mag;
    logic [XY_WDT+1:0]      res_ph;

    modport master (
        output req_vld, req_x, req_y,
        input  req_ack, res_vld, res_id, res_mag, res_ph
    );
    modport slave (
        input  req_vld, req_x, req_y,
        output req_ack, res_vld, res_id, res_mag, res_ph
    );
endinterface

interface cordic_core_if #(
    parameter int unsigned XY_WDT = 16
);
    logic              core_en;
    logic              core_st;
    logic [XY_WDT-1:0] core_xin;
    logic [XY_WDT-1:0] core_yin;
    logic              core_rdy;
    logic [XY_WDT-1:0] core_mag;
    logic [XY_WDT+1:0] core_ph;

    modport master (
        output core_en, core_st, core_xin, core_yin,
        input  core_rdy, core_mag, core_ph
    );
    modport slave (
        input  core_en, core_st, core_xin, core_yin,
        output core_rdy, core_mag, core_ph
    );
endinterface

// File: rtl/cordic_magph_arb_rr_arbiter.sv
// NREQ-wide round-robin arbiter: combinational grant, registered priority pointer.
// The pointer moves past the granted index only when upd_i strobes.
module rr_arbiter
    import cordic_magph_arb_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    localparam int unsigned ID_WDT = id_wdt(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic              upd_i,
    output logic              gnt_vld_c,
    output logic [ID_WDT-1:0] gnt_idx_c
);

    logic [ID_WDT-1:0] ptr_q, ptr_d;
    pick_t             pick_c;

    always_comb begin
        pick_c    = rr_pick(MAX_REQ'(req_i), MAX_ID_WDT'(ptr_q), NREQ);
        gnt_vld_c = pick_c.vld;
        gnt_idx_c = ID_WDT'(pick_c.idx);
        ptr_d     = ptr_q;
        if (upd_i && pick_c.vld) begin
            ptr_d = (gnt_idx_c == ID_WDT'(NREQ - 1)) ? '0 : gnt_idx_c + ID_WDT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cordic_magph_arb.sv
// Round-robin sharing of one serial cordicMagPh core between NREQ requesters.
// Optional watchdog on the core handshake: define CORDIC_ARB_TMO_EN.
module cordic_magph_arb
    import cordic_magph_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned XY_WDT = 16,
    parameter int unsigned TMO    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    cordic_req_if.slave   req,
    cordic_core_if.master core,
    output logic          err_tmo
);

    localparam int unsigned ID_WDT = id_wdt(NREQ);
    localparam int unsigned PH_WDT = XY_WDT + 2;

    if (NREQ < 2 || NREQ > MAX_REQ || TMO < 2) begin : g_param_chk
        $error("cordic_magph_arb: NREQ must be 2..16 and TMO at least 2");
    end

    state_t            state_q, state_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              st_q, st_d;
    logic              res_vld_q, res_vld_d;
    logic [ID_WDT-1:0] tag_q, tag_d;
    logic [ID_WDT-1:0] res_id_q, res_id_d;
    logic [XY_WDT-1:0] mag_q, mag_d;
    logic [PH_WDT-1:0] ph_q, ph_d;
    logic [XY_WDT-1:0] xin_q, xin_d;
    logic [XY_WDT-1:0] yin_q, yin_d;
    logic              gnt_vld_c;
    logic [ID_WDT-1:0] gnt_idx_c;
    logic              arb_upd_c;
    logic              tmo_hit_c;

    assign arb_upd_c = (state_q == ARB) && gnt_vld_c;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en),
        .req_i     (req.req_vld),
        .upd_i     (arb_upd_c),
        .gnt_vld_c (gnt_vld_c),
        .gnt_idx_c (gnt_idx_c)
    );

`ifdef CORDIC_ARB_TMO_EN
    localparam int unsigned CNT_WDT = $clog2(TMO + 1);

    logic [CNT_WDT-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               in_wait_c;

    // A result arriving on the last allowed cycle still wins over the watchdog.
    assign in_wait_c = (state_q == BUSY) || (state_q == DONE);
    assign tmo_hit_c = in_wait_c && (cnt_q == CNT_WDT'(TMO - 1))
                       && !((state_q == DONE) && core.core_rdy);

    always_comb begin
        cnt_d = in_wait_c ? cnt_q + CNT_WDT'(1) : '0;
        err_d = err_q | tmo_hit_c;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (en) begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_tmo = err_q;
`else
    assign tmo_hit_c = 1'b0;
    assign err_tmo   = 1'b0;
`endif

    // State and output registers; en==0 freezes everything in lockstep with the core.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= BOOT;
            ack_q     <= '0;
            st_q      <= 1'b0;
            res_vld_q <= 1'b0;
            tag_q     <= '0;
            res_id_q  <= '0;
            mag_q     <= '0;
            ph_q      <= '0;
            xin_q     <= '0;
            yin_q     <= '0;
        end else if (en) begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            st_q      <= st_d;
            res_vld_q <= res_vld_d;
            tag_q     <= tag_d;
            res_id_q  <= res_id_d;
            mag_q     <= mag_d;
            ph_q      <= ph_d;
            xin_q     <= xin_d;
            yin_q     <= yin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    if (core.core_rdy) state_d = ARB;
            ARB:     if (gnt_vld_c) state_d = START;
            START:   state_d = BUSY;
            BUSY: begin
                if (tmo_hit_c)          state_d = BOOT;
                else if (!core.core_rdy) state_d = DONE;
            end
            DONE: begin
                if (core.core_rdy)  state_d = ARB;
                else if (tmo_hit_c) state_d = BOOT;
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        ack_d     = '0;
        st_d      = 1'b0;
        res_vld_d = 1'b0;
        tag_d     = tag_q;
        res_id_d  = res_id_q;
        mag_d     = mag_q;
        ph_d      = ph_q;
        xin_d     = xin_q;
        yin_d     = yin_q;
        unique case (state_q)
            ARB: begin
                if (gnt_vld_c) begin
                    ack_d = NREQ'(1) << gnt_idx_c;
                    xin_d = req.req_x[gnt_idx_c*XY_WDT +: XY_WDT];
                    yin_d = req.req_y[gnt_idx_c*XY_WDT +: XY_WDT];
                    tag_d = gnt_idx_c;
                end
            end
            START: st_d = 1'b1;
            DONE: begin
                if (core.core_rdy) begin
                    res_vld_d = 1'b1;
                    res_id_d  = tag_q;
                    mag_d     = core.core_mag;
                    ph_d      = core.core_ph;
                end else if (tmo_hit_c) begin
                    res_vld_d = 1'b1;
                    res_id_d  = tag_q;
                    mag_d     = '0;
                    ph_d      = '0;
                end
            end
            BUSY: begin
                if (tmo_hit_c) begin
                    res_vld_d = 1'b1;
                    res_id_d  = tag_q;
                    mag_d     = '0;
                    ph_d      = '0;
                end
            end
            default: ;
        endcase
    end

    assign req.req_ack  = ack_q;
    assign req.res_vld  = res_vld_q;
    assign req.res_id   = res_id_q;
    assign req.res_mag  = mag_q;
    assign req.res_ph   = ph_q;
    assign core.core_en  = en;
    assign core.core_st  = st_q;
    assign core.core_xin = xin_q;
    assign core.core_yin = yin_q;

endmodule

// File: tb/tb_cordic_magph_arb.sv
// Directed bench for cordic_magph_arb with a small latency-accurate serial core stand-in.
// The stand-in returns mag = x + y and ph = {y, 2'b00} after LAT enabled cycles.
module tb_cordic_magph_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned XW   = 16;
    localparam int unsigned LAT  = 5;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic en         = 1'b1;
    logic core_block = 1'b1;
    logic err_tmo;
    int   checks     = 0;
    int   errors     = 0;

    always #5 clk = ~clk;

    cordic_req_if  #(.NREQ(NREQ), .XY_WDT(XW)) rq ();
    cordic_core_if #(.XY_WDT(XW))              cr ();

    cordic_magph_arb #(.NREQ(NREQ), .XY_WDT(XW), .TMO(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .req     (rq),
        .core    (cr),
        .err_tmo (err_tmo)
    );

    // Serial core stand-in: rdy drops after st, returns LAT enabled cycles later.
    logic        stub_rdy = 1'b1;
    logic [3:0]  stub_cnt = '0;
    logic [15:0] sx = '0, sy = '0, stub_mag = '0;
    logic [17:0] stub_ph = '0;

    assign cr.core_rdy = stub_rdy & ~core_block;
    assign cr.core_mag = stub_mag;
    assign cr.core_ph  = stub_ph;

    always @(posedge clk) begin
        if (cr.core_en) begin
            if (stub_rdy) begin
                if (cr.core_st) begin
                    stub_rdy <= 1'b0;
                    stub_cnt <= 4'(LAT);
                    sx       <= cr.core_xin;
                    sy       <= cr.core_yin;
                end
            end else begin
                if (stub_cnt == 4'd1) begin
                    stub_rdy <= 1'b1;
                    stub_mag <= sx + sy;
                    stub_ph  <= {sy, 2'b00};
                end
                stub_cnt <= stub_cnt - 4'd1;
            end
        end
    end

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y);
        rq.req_x[i*XW +: XW] = x;
        rq.req_y[i*XW +: XW] = y;
        rq.req_vld[i]        = 1'b1;
    endtask

    task automatic wait_ack(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (|rq.req_ack) begin
                ok = 1'b1;
                for (int i = 0; i < int'(NREQ); i++) if (rq.req_ack[i]) idx = i;
            end
        end
    endtask

    // Cycles counted from the current negedge; optionally drops en for gap_len cycles.
    task automatic wait_res(input int gap_at, input int gap_len, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 200 && !ok; c++) begin
            if (gap_len > 0 && c == gap_at)           en = 1'b0;
            if (gap_len > 0 && c == gap_at + gap_len) en = 1'b1;
            @(negedge clk);
            if (rq.res_vld) begin
                ok  = 1'b1;
                cyc = c;
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset();
        int saw;
        reset      = 1'b0;
        core_block = 1'b1;
        rq.req_x   = '0;
        rq.req_y   = '0;
        rq.req_vld = '1;
        repeat (10) @(negedge clk);
        checks++;
        if ({rq.req_ack, rq.res_vld, cr.core_st, rq.res_id, rq.res_mag, rq.res_ph,
             cr.core_xin, cr.core_yin, err_tmo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%h vld=%b st=%b id=%0d mag=%0d ph=%0d xin=%0d yin=%0d err=%b, expected all 0",
                     rq.req_ack, rq.res_vld, cr.core_st, rq.res_id, rq.res_mag, rq.res_ph,
                     cr.core_xin, cr.core_yin, err_tmo);
        end
        checks++;
        if (cr.core_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_core_en: got %b expected 1", cr.core_en);
        end
        reset = 1'b1;
        saw   = 0;
        repeat (8) begin
            @(negedge clk);
            if (cr.core_st || (|rq.req_ack)) saw++;
        end
        checks++;
        if (saw !== 0) begin
            errors++;
            $display("FAIL boot_waits_rdy: got %0d st/ack cycles expected 0", saw);
        end
        rq.req_vld = '0;
        core_block = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int idx, cyc;
        bit ok;
        set_req(2, 16'd16384, 16'd0);
        wait_ack(idx, ok);
        rq.req_vld[2] = 1'b0;
        checks++;
        if (idx !== 2) begin
            errors++;
            $display("FAIL single_ack: got idx %0d expected 2", idx);
        end
        checks++;
        if (cr.core_xin !== 16'd16384 || cr.core_yin !== 16'd0) begin
            errors++;
            $display("FAIL single_core_xy: got %0d/%0d expected 16384/0", cr.core_xin, cr.core_yin);
        end
        @(negedge clk);
        checks++;
        if (rq.req_ack !== 4'b0000 || cr.core_st !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_to_st: got ack=%b st=%b expected 0000/1", rq.req_ack, cr.core_st);
        end
        wait_res(0, 0, cyc, ok);
        checks++;
        if (!ok || rq.res_id !== 2'd2 || rq.res_mag !== 16'd16384 || rq.res_ph !== 18'd0) begin
            errors++;
            $display("FAIL single_result: got ok=%b id=%0d mag=%0d ph=%0d expected 1/2/16384/0",
                     ok, rq.res_id, rq.res_mag, rq.res_ph);
        end
        @(negedge clk);
        checks++;
        if (rq.res_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_res_pulse: got res_vld %b expected 0", rq.res_vld);
        end
    endtask

    task automatic test_fairness();
        int idx, cyc, e;
        bit ok;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'(1000 * (i + 1)), 16'(10 * (i + 1)));
        for (int k = 0; k < 8; k++) begin
            e = k % 4;
            wait_ack(idx, ok);
            checks++;
            if (idx !== e) begin
                errors++;
                $display("FAIL fair_grant%0d: got idx %0d expected %0d", k, idx, e);
            end
            wait_res(0, 0, cyc, ok);
            if (k == 7) rq.req_vld = '0;
            checks++;
            if (!ok || rq.res_id !== 2'(e) || rq.res_mag !== 16'(1010 * (e + 1))
                || rq.res_ph !== 18'(40 * (e + 1))) begin
                errors++;
                $display("FAIL fair_result%0d: got ok=%b id=%0d mag=%0d ph=%0d expected id %0d mag %0d ph %0d",
                         k, ok, rq.res_id, rq.res_mag, rq.res_ph, e, 1010 * (e + 1), 40 * (e + 1));
            end
        end
    endtask

    task automatic test_withdraw();
        int idx, cyc;
        bit ok;
        set_req(0, 16'd30, 16'd5);
        wait_ack(idx, ok);
        rq.req_vld[0] = 1'b0;
        set_req(3, 16'd70, 16'd9);
        checks++;
        if (idx !== 0) begin
            errors++;
            $display("FAIL withdraw_first: got idx %0d expected 0", idx);
        end
        repeat (2) @(negedge clk);
        set_req(1, 16'd11, 16'd11);
        @(negedge clk);
        rq.req_vld[1] = 1'b0;
        wait_res(0, 0, cyc, ok);
        checks++;
        if (!ok || rq.res_id !== 2'd0 || rq.res_mag !== 16'd35) begin
            errors++;
            $display("FAIL withdraw_res0: got ok=%b id=%0d mag=%0d expected 1/0/35", ok, rq.res_id, rq.res_mag);
        end
        wait_ack(idx, ok);
        rq.req_vld[3] = 1'b0;
        checks++;
        if (idx !== 3) begin
            errors++;
            $display("FAIL withdraw_next: got idx %0d expected 3", idx);
        end
        wait_res(0, 0, cyc, ok);
        checks++;
        if (!ok || rq.res_id !== 2'd3 || rq.res_mag !== 16'd79 || rq.res_ph !== 18'd36) begin
            errors++;
            $display("FAIL withdraw_res3: got ok=%b id=%0d mag=%0d ph=%0d expected 1/3/79/36",
                     ok, rq.res_id, rq.res_mag, rq.res_ph);
        end
    endtask

    task automatic test_en_gating();
        int idx, cyc0, cyc1;
        bit ok;
        @(negedge clk);
        en = 1'b0;
        #1;
        checks++;
        if (cr.core_en !== 1'b0) begin
            errors++;
            $display("FAIL core_en_follow: got %b expected 0", cr.core_en);
        end
        @(negedge clk);
        en = 1'b1;
        set_req(1, 16'd500, 16'd20);
        wait_ack(idx, ok);
        rq.req_vld[1] = 1'b0;
        wait_res(0, 0, cyc0, ok);
        checks++;
        if (!ok || cyc0 !== 8 || rq.res_id !== 2'd1 || rq.res_mag !== 16'd520 || rq.res_ph !== 18'd80) begin
            errors++;
            $display("FAIL en_baseline: got ok=%b cyc=%0d id=%0d mag=%0d ph=%0d expected 1/8/1/520/80",
                     ok, cyc0, rq.res_id, rq.res_mag, rq.res_ph);
        end
        set_req(2, 16'd500, 16'd20);
        wait_ack(idx, ok);
        rq.req_vld[2] = 1'b0;
        wait_res(3, 7, cyc1, ok);
        checks++;
        if (!ok || cyc1 !== 15 || rq.res_id !== 2'd2 || rq.res_mag !== 16'd520 || rq.res_ph !== 18'd80) begin
            errors++;
            $display("FAIL en_gated: got ok=%b cyc=%0d id=%0d mag=%0d ph=%0d expected 1/15/2/520/80",
                     ok, cyc1, rq.res_id, rq.res_mag, rq.res_ph);
        end
    endtask

    task automatic test_reset_mid();
        int idx, cyc, saw;
        bit ok;
        set_req(0, 16'd7, 16'd3);
        wait_ack(idx, ok);
        rq.req_vld[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rq.res_vld, cr.core_st, rq.req_ack, cr.core_xin, rq.res_mag, rq.res_id} !== '0) begin
            errors++;
            $display("FAIL midreset_clear: got vld=%b st=%b ack=%h xin=%0d mag=%0d id=%0d expected all 0",
                     rq.res_vld, cr.core_st, rq.req_ack, cr.core_xin, rq.res_mag, rq.res_id);
        end
        @(negedge clk);
        reset = 1'b1;
        saw   = 0;
        repeat (25) begin
            @(negedge clk);
            if (rq.res_vld) saw++;
        end
        checks++;
        if (saw !== 0) begin
            errors++;
            $display("FAIL midreset_no_result: got %0d res_vld expected 0", saw);
        end
        set_req(0, 16'd1, 16'd1);
        set_req(3, 16'd2, 16'd2);
        wait_ack(idx, ok);
        rq.req_vld[0] = 1'b0;
        checks++;
        if (idx !== 0) begin
            errors++;
            $display("FAIL midreset_ptr: got idx %0d expected 0", idx);
        end
        wait_res(0, 0, cyc, ok);
        wait_ack(idx, ok);
        rq.req_vld[3] = 1'b0;
        wait_res(0, 0, cyc, ok);
        checks++;
        if (!ok || rq.res_id !== 2'd3 || rq.res_mag !== 16'd4) begin
            errors++;
            $display("FAIL midreset_recover: got ok=%b id=%0d mag=%0d expected 1/3/4", ok, rq.res_id, rq.res_mag);
        end
    endtask

    task automatic test_watchdog();
        int idx, cyc, saw;
        bit ok;
        core_block = 1'b1;
        set_req(1, 16'd9, 16'd9);
        wait_ack(idx, ok);
        rq.req_vld[1] = 1'b0;
`ifdef CORDIC_ARB_TMO_EN
        wait_res(0, 0, cyc, ok);
        checks++;
        if (!ok || cyc !== 9 || rq.res_id !== 2'd1 || rq.res_mag !== 16'd0 || rq.res_ph !== 18'd0
            || err_tmo !== 1'b1) begin
            errors++;
            $display("FAIL tmo_result: got ok=%b cyc=%0d id=%0d mag=%0d ph=%0d err=%b expected 1/9/1/0/0/1",
                     ok, cyc, rq.res_id, rq.res_mag, rq.res_ph, err_tmo);
        end
        set_req(2, 16'd1, 16'd1);
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (|rq.req_ack || err_tmo !== 1'b1) saw++;
        end
        rq.req_vld = '0;
        checks++;
        if (saw !== 0) begin
            errors++;
            $display("FAIL tmo_sticky_boot: got %0d bad cycles expected 0", saw);
        end
        core_block = 1'b0;
`else
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (rq.res_vld || err_tmo !== 1'b0) saw++;
        end
        checks++;
        if (saw !== 0) begin
            errors++;
            $display("FAIL stall_waits: got %0d bad cycles expected 0", saw);
        end
        core_block = 1'b0;
        wait_res(0, 0, cyc, ok);
        checks++;
        if (!ok || rq.res_id !== 2'd1 || rq.res_mag !== 16'd18 || rq.res_ph !== 18'd36) begin
            errors++;
            $display("FAIL stall_result: got ok=%b id=%0d mag=%0d ph=%0d expected 1/1/18/36",
                     ok, rq.res_id, rq.res_mag, rq.res_ph);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_withdraw();
        test_en_gating();
        test_reset_mid();
        test_watchdog();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000");
        $fatal(1, "global timeout");
    end

endmodule
